axi_grid_vh_split: RTL
======================

AXI_GRID_VH_SPLIT -- requirements
Module: axi_grid_vh_split

Interface
REQ-001 SHALL have parameter grid_id_t, default axi_default_param_pkg::grid_id_t, meaning packed grid node ID; upper half = row (Y), lower half = column (X).
REQ-002 SHALL have parameter chan_t, default axi_default_param_pkg::grid_id_t, meaning the payload type carried per beat.
REQ-003 SHALL have parameter NI_ID, type grid_id_t, default 0, meaning this node's grid ID.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port srst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have ports did_i/sid_i, input, grid_id_t: destination and source ID of the input beat.
REQ-007 SHALL have port chan_i, input, chan_t: the input payload.
REQ-008 SHALL have ports valid_i (input, 1 bit) and ready_o (output, 1 bit): the input handshake.
REQ-009 SHALL have ports v_did_o/v_sid_o, output, grid_id_t; v_chan_o, output, chan_t: the vertical output beat.
REQ-010 SHALL have ports v_valid_o (output, 1 bit) and v_ready_i (input, 1 bit): the vertical handshake.
REQ-011 SHALL have ports h_did_o/h_sid_o, output, grid_id_t; h_chan_o, output, chan_t: the horizontal output beat.
REQ-012 SHALL have ports h_valid_o (output, 1 bit) and h_ready_i (input, 1 bit): the horizontal handshake.

Function
REQ-013 SHALL route each beat by XY routing: did_i column != NI_ID column -> horizontal; otherwise -> vertical, including did_i == NI_ID.
REQ-014 SHALL route from did_i only; sid_i and chan_i SHALL pass unmodified.
REQ-015 SHALL give each output its own 2-entry FIFO: storage {did, sid, chan}, 1-bit write pointer, 1-bit read pointer, 2-bit count 0..2.
REQ-016 SHALL drive ready_o = (count < 2) of the selected FIFO; ready_o SHALL depend on did_i and that count only, never on v_ready_i or h_ready_i.
REQ-017 SHALL push into the selected FIFO when valid_i && ready_o; the other FIFO is untouched.
REQ-018 SHALL drive x_valid_o = (count != 0), with x_did_o/x_sid_o/x_chan_o taken from the head entry.
REQ-019 SHALL pop on x_valid_o && x_ready_i.
REQ-020 SHALL have a latency of exactly 1 cycle from input handshake to x_valid_o, with no combinational pass-through.
REQ-021 SHALL, on simultaneous push and pop on the same FIFO, keep count unchanged and advance both pointers.
REQ-022 SHALL hold ready_o low for beats routed to a FIFO at count 2, even if that FIFO pops in the same cycle.
REQ-023 SHALL hold output data stable while x_valid_o && !x_ready_i; a FIFO SHALL never drop or duplicate a beat.
REQ-024 SHALL let a stalled FIFO block only beats routed to it; beats routed to the other FIFO proceed.
REQ-025 SHALL preserve per-output order; there is no ordering guarantee between v and h.
REQ-026 SHALL wrap pointers modulo 2.
REQ-027 SHALL sustain 1 beat/cycle per output when x_ready_i is held high.

Reset
REQ-028 SHALL, on a clk_i edge with srst_i=1, clear counts, pointers and storage to 0.
REQ-029 SHALL hold v_valid_o = h_valid_o = 0 and all data outputs 0 during and after reset until the next push.
REQ-030 SHALL hold ready_o = 1 (both FIFOs empty) out of reset.
REQ-031 SHALL, on reset mid-operation, discard buffered beats; handshakes in the reset cycle SHALL have no effect.

Structure
REQ-032 SHALL keep grid_id_t, chan_t defaults and row/column field helpers in axi_default_param_pkg.
REQ-033 SHALL implement the 2-entry FIFO as sub-module axi_grid_fifo2 (parameter data type, same clk_i/srst_i), instantiated twice.
REQ-034 SHALL be the inverse of the vertical/horizontal join: split output pairs SHALL connect directly to join inputs.

Verification (grid_id_t 8-bit, row [7:4], column [3:0], NI_ID=8'h12)
REQ-035 SHALL cover: did_i=8'h15, chan=A, both readies high -> h_valid_o next cycle with A, v_valid_o stays 0.
REQ-036 SHALL cover: did_i=8'h32, then 8'h12 -> both beats appear on v in order, 1-cycle latency each.
REQ-037 SHALL cover: h_ready_i=0, three beats to 8'h15 -> two accepted, ready_o=0 on the third; h_ready_i=1 -> both drain in order, third accepted after the first pop.
REQ-038 SHALL cover: h full and stalled, beat to 8'h32 -> accepted, v_valid_o next cycle.
REQ-039 SHALL cover: back-to-back alternating v/h beats with both readies high -> 1 beat/cycle, no bubbles.
REQ-040 SHALL cover: srst_i=1 while both FIFOs hold 2 beats -> next cycle both valids 0, data outputs 0, ready_o=1.

Source files
------------

// File: rtl/axi_default_param_pkg.sv
// Default grid types for the AXI grid network: packed node ID with row in the
// upper half and column in the lower half, plus field helpers.
package axi_default_param_pkg;

  localparam int unsigned GridIdW = 8;
  localparam int unsigned GridFldW = GridIdW / 2;

  typedef logic [GridIdW-1:0] grid_id_t;

  function automatic logic [GridFldW-1:0] grid_row(input grid_id_t id);
    return id[GridIdW-1:GridFldW];
  endfunction

  function automatic logic [GridFldW-1:0] grid_col(input grid_id_t id);
    return id[GridFldW-1:0];
  endfunction

endpackage

// File: rtl/axi_grid_fifo2.sv
// Two-entry registered FIFO with full/valid flags; entries and pointers are
// cleared on reset so the head reads as zero until the first push.
module axi_grid_fifo2 #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  srst_i,
  input  logic  push_i,
  input  data_t data_i,
  output logic  full_o,
  input  logic  pop_i,
  output logic  valid_o,
  output data_t data_o
);

  data_t       r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_cnt;
  logic        w_push;
  logic        w_pop;

  assign full_o  = (r_cnt == 2'd2);
  assign valid_o = (r_cnt != 2'd0);
  assign data_o  = r_mem[r_rptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && valid_o;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_grid_vh_split.sv
// XY-routing split: beats whose destination column differs from this node go
// horizontal, all others vertical; each output is buffered by its own FIFO.
module axi_grid_vh_split #(
  parameter type grid_id_t = axi_default_param_pkg::grid_id_t,
  parameter type chan_t    = axi_default_param_pkg::grid_id_t,
  parameter grid_id_t NI_ID = '0
) (
  input  logic     clk_i,
  input  logic     srst_i,
  input  grid_id_t did_i,
  input  grid_id_t sid_i,
  input  chan_t    chan_i,
  input  logic     valid_i,
  output logic     ready_o,
  output grid_id_t v_did_o,
  output grid_id_t v_sid_o,
  output chan_t    v_chan_o,
  output logic     v_valid_o,
  input  logic     v_ready_i,
  output grid_id_t h_did_o,
  output grid_id_t h_sid_o,
  output chan_t    h_chan_o,
  output logic     h_valid_o,
  input  logic     h_ready_i
);

  localparam int unsigned ColW = $bits(grid_id_t) / 2;

  typedef struct packed {
    grid_id_t did;
    grid_id_t sid;
    chan_t    chan;
  } beat_t;

  logic [ColW-1:0] w_did_col;
  logic            w_to_h;
  logic            w_v_full;
  logic            w_h_full;
  logic            w_push;
  beat_t           w_beat;
  beat_t           w_v_head;
  beat_t           w_h_head;

  assign w_did_col = did_i[ColW-1:0];
  assign w_to_h    = (w_did_col != NI_ID[ColW-1:0]);

  // Ready looks only at the selected FIFO's fill level, never at the output
  // readies, so a full FIFO refuses even when it is popping this cycle.
  assign ready_o = w_to_h ? !w_h_full : !w_v_full;
  assign w_push  = valid_i && ready_o;
  assign w_beat  = '{did: did_i, sid: sid_i, chan: chan_i};

  axi_grid_fifo2 #(.data_t(beat_t)) u_v_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (w_push && !w_to_h),
    .data_i  (w_beat),
    .full_o  (w_v_full),
    .pop_i   (v_ready_i),
    .valid_o (v_valid_o),
    .data_o  (w_v_head)
  );

  axi_grid_fifo2 #(.data_t(beat_t)) u_h_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (w_push && w_to_h),
    .data_i  (w_beat),
    .full_o  (w_h_full),
    .pop_i   (h_ready_i),
    .valid_o (h_valid_o),
    .data_o  (w_h_head)
  );

  assign v_did_o  = w_v_head.did;
  assign v_sid_o  = w_v_head.sid;
  assign v_chan_o = w_v_head.chan;
  assign h_did_o  = w_h_head.did;
  assign h_sid_o  = w_h_head.sid;
  assign h_chan_o = w_h_head.chan;

endmodule
